// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON packet receiver slice.
package simon_pkg;

  localparam int unsigned SIMON_N    = 16;
  localparam int unsigned SIMON_M    = 4;

  localparam int unsigned INFO_KEY   = 5;
  localparam int unsigned INFO_ENC   = 6;

  localparam int unsigned DATA_BYTES = 2 * SIMON_N / 8;
  localparam int unsigned KEY_BYTES  = SIMON_M * SIMON_N / 8;

  typedef enum logic [1:0] {
    HEAD,
    CNT,
    PAY,
    COMMIT
  } rx_state_t;

endpackage

// File: rtl/simon_rise_detect.sv
// Synchronous rising-edge detector: flags a level that is high now but was low on the previous edge.
module simon_rise_detect (
  input  logic clk,
  input  logic nR,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) prev_q <= 1'b0;
    else     prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/simon_packet_rx.sv
// Byte-serial packet receiver feeding the SIMON cipher: assembles header/count/payload
// and holds one finished packet in an output slot until the cipher acknowledges it.
module simon_packet_rx
  import simon_pkg::*;
#(
  parameter int unsigned N = SIMON_N,
  parameter int unsigned M = SIMON_M
) (
  input  logic           clk,
  input  logic           nR,
  input  logic [7:0]     rxDATA,
  input  logic           rxVALID,
  input  logic           rxSOF,
  output logic           rxREADY,
  input  logic           loadDATA,
  input  logic           loadKEY,
  output logic [7:0]     infoIN,
  output logic [7:0]     countIN,
  output logic [2*N-1:0] inDATA,
  output logic [M*N-1:0] KEY,
  output logic           newDATA,
  output logic           newKEY,
  output logic           rxERR
);

  localparam int unsigned DATA_B = 2 * N / 8;
  localparam int unsigned KEY_B  = M * N / 8;
  localparam int unsigned CW     = $clog2(KEY_B + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_B - 1);
  localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_B - 1);

  rx_state_t        state_q, state_d;
  logic             live_q;
  logic [7:0]       hdr_q, hdr_d;
  logic [7:0]       cntb_q, cntb_d;
  logic [CW-1:0]    pcnt_q, pcnt_d;
  logic [M*N-1:0]   asm_q, asm_d;
  logic [7:0]       info_q, info_d;
  logic [7:0]       count_q, count_d;
  logic [2*N-1:0]   data_q, data_d;
  logic [M*N-1:0]   key_q, key_d;
  logic             newd_q, newd_d;
  logic             newk_q, newk_d;
  logic             err_q, err_d;

  logic             ld_rise, lk_rise;
  logic             accept;
  logic [CW-1:0]    last_idx;

  simon_rise_detect u_rise_data (
    .clk    (clk),
    .nR     (nR),
    .lvl_i  (loadDATA),
    .rise_o (ld_rise)
  );

  simon_rise_detect u_rise_key (
    .clk    (clk),
    .nR     (nR),
    .lvl_i  (loadKEY),
    .rise_o (lk_rise)
  );

  // Ready is held low until the first edge after reset release.
  assign rxREADY  = live_q && (state_q != COMMIT);
  assign accept   = rxVALID && rxREADY;
  assign last_idx = hdr_q[INFO_KEY] ? KEY_LAST : DATA_LAST;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cntb_d  = cntb_q;
    pcnt_d  = pcnt_q;
    asm_d   = asm_q;
    info_d  = info_q;
    count_d = count_q;
    data_d  = data_q;
    key_d   = key_q;
    newd_d  = newd_q;
    newk_d  = newk_q;
    err_d   = 1'b0;

    if (ld_rise && newd_q) newd_d = 1'b0;
    if (lk_rise && newk_q) newk_d = 1'b0;

    unique case (state_q)
      HEAD: begin
        if (accept) begin
          if (rxSOF) begin
            hdr_d   = rxDATA;
            state_d = CNT;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      CNT, PAY: begin
        if (accept) begin
          if (rxSOF) begin
            hdr_d   = rxDATA;
            err_d   = 1'b1;
            state_d = CNT;
          end else if (state_q == CNT) begin
            cntb_d  = rxDATA;
            pcnt_d  = '0;
            state_d = PAY;
          end else begin
            for (int unsigned k = 0; k < KEY_B; k++) begin
              if (pcnt_q == CW'(k)) asm_d[8*k +: 8] = rxDATA;
            end
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q == last_idx) state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        // Slot occupancy is judged before this edge's acknowledge takes effect.
        if (!(newd_q || newk_q)) begin
          info_d  = hdr_q;
          count_d = cntb_q;
          if (hdr_q[INFO_KEY]) begin
            key_d  = asm_q;
            newk_d = 1'b1;
          end else begin
            data_d = asm_q[2*N-1:0];
            newd_d = 1'b1;
          end
          state_d = HEAD;
        end
      end
      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q <= HEAD;
      live_q  <= 1'b0;
      hdr_q   <= '0;
      cntb_q  <= '0;
      pcnt_q  <= '0;
      asm_q   <= '0;
      info_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      key_q   <= '0;
      newd_q  <= 1'b0;
      newk_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      hdr_q   <= hdr_d;
      cntb_q  <= cntb_d;
      pcnt_q  <= pcnt_d;
      asm_q   <= asm_d;
      info_q  <= info_d;
      count_q <= count_d;
      data_q  <= data_d;
      key_q   <= key_d;
      newd_q  <= newd_d;
      newk_q  <= newk_d;
      err_q   <= err_d;
    end
  end

  assign infoIN  = info_q;
  assign countIN = count_q;
  assign inDATA  = data_q;
  assign KEY     = key_q;
  assign newDATA = newd_q;
  assign newKEY  = newk_q;
  assign rxERR   = err_q;

endmodule

// File: tb/tb_simon_packet_rx.sv
// Directed bench for simon_packet_rx with a packet scoreboard (N=16, M=4).
module tb_simon_packet_rx;

  localparam int unsigned N = 16;
  localparam int unsigned M = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        is_key;
    logic [7:0]  info;
    logic [7:0]  count;
    logic [31:0] data;
    logic [63:0] key;
  } exp_t;

  logic           clk = 1'b0;
  logic           nR;
  logic [7:0]     rxDATA;
  logic           rxVALID;
  logic           rxSOF;
  logic           rxREADY;
  logic           loadDATA;
  logic           loadKEY;
  logic [7:0]     infoIN;
  logic [7:0]     countIN;
  logic [2*N-1:0] inDATA;
  logic [M*N-1:0] KEY;
  logic           newDATA;
  logic           newKEY;
  logic           rxERR;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [31:0] last_data;
  logic [63:0] last_key;

  simon_packet_rx #(.N(N), .M(M)) dut (
    .clk      (clk),
    .nR       (nR),
    .rxDATA   (rxDATA),
    .rxVALID  (rxVALID),
    .rxSOF    (rxSOF),
    .rxREADY  (rxREADY),
    .loadDATA (loadDATA),
    .loadKEY  (loadKEY),
    .infoIN   (infoIN),
    .countIN  (countIN),
    .inDATA   (inDATA),
    .KEY      (KEY),
    .newDATA  (newDATA),
    .newKEY   (newKEY),
    .rxERR    (rxERR)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bq_t b);
    exp_t        e;
    logic [63:0] vec;
    vec      = '0;
    e        = '0;
    e.is_key = b[0][5];
    e.info   = b[0];
    e.count  = b[1];
    for (int k = 0; k < b.size() - 2; k++) vec[8*k +: 8] = b[k+2];
    if (e.is_key) e.key = vec;
    else          e.data = vec[31:0];
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic sof);
    int unsigned budget;
    budget = 0;
    @(negedge clk);
    rxDATA  = b;
    rxSOF   = sof;
    rxVALID = 1'b1;
    while (!rxREADY && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!rxREADY) chk("rx_ready_timeout", {127'd0, rxREADY}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rxVALID = 1'b0;
    rxSOF   = 1'b0;
  endtask

  task automatic send_pkt(input bq_t b);
    sb.push_back(model(b));
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == 0);
  endtask

  task automatic wait_new();
    int unsigned budget;
    budget = 0;
    while (!(newDATA || newKEY) && budget < 60) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("new_timeout", {127'd0, newDATA | newKEY}, 128'd1);
  endtask

  task automatic check_pkt(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 128'(sb.size()), 128'd1);
    end else begin
      e = sb.pop_front();
      if (e.is_key) last_key = e.key;
      else          last_data = e.data;
      chk({tag, "_newKEY"},  {127'd0, newKEY},  {127'd0, e.is_key});
      chk({tag, "_newDATA"}, {127'd0, newDATA}, {127'd0, ~e.is_key});
      chk({tag, "_info"},    128'(infoIN),      128'(e.info));
      chk({tag, "_count"},   128'(countIN),     128'(e.count));
      chk({tag, "_data"},    128'(inDATA),      128'(last_data));
      chk({tag, "_key"},     128'(KEY),         128'(last_key));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rxREADY"}, {127'd0, rxREADY}, 128'd0);
    chk({tag, "_newDATA"}, {127'd0, newDATA}, 128'd0);
    chk({tag, "_newKEY"},  {127'd0, newKEY},  128'd0);
    chk({tag, "_rxERR"},   {127'd0, rxERR},   128'd0);
    chk({tag, "_info"},    128'(infoIN),      128'd0);
    chk({tag, "_count"},   128'(countIN),     128'd0);
    chk({tag, "_data"},    128'(inDATA),      128'd0);
    chk({tag, "_key"},     128'(KEY),         128'd0);
  endtask

  initial begin
    bq_t p;
    nR = 1'b0; rxDATA = '0; rxVALID = 1'b0; rxSOF = 1'b0;
    loadDATA = 1'b0; loadKEY = 1'b0;
    last_data = '0; last_key = '0;

    // Reset state and release.
    #2;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); nR = 1'b1;
    #1 chk("ready_before_first_edge", {127'd0, rxREADY}, 128'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {127'd0, rxREADY}, 128'd1);

    // Data packet at full rate, with latency check.
    p = {8'h40, 8'h07, 8'h65, 8'h65, 8'h68, 8'h77};
    send_pkt(p);
    chk("lat_last_byte_edge", {127'd0, newDATA}, 128'd0);
    @(posedge clk); #1;
    chk("lat_commit_edge", {127'd0, newDATA}, 128'd1);
    idle();
    check_pkt("data1");
    chk("data1_words", 128'(inDATA), 128'h7768_6565);
    chk("data1_ready_head", {127'd0, rxREADY}, 128'd1);

    // Acknowledge data: flag drops, outputs hold.
    @(negedge clk); loadDATA = 1'b1;
    @(posedge clk); #1;
    chk("ack1_newDATA", {127'd0, newDATA}, 128'd0);
    chk("ack1_info_hold", 128'(infoIN), 128'h40);
    chk("ack1_data_hold", 128'(inDATA), 128'h7768_6565);
    @(negedge clk); loadDATA = 1'b0;

    // Key packet.
    p = {8'h60, 8'h01, 8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11, 8'h18, 8'h19};
    send_pkt(p);
    idle();
    wait_new();
    check_pkt("key1");
    chk("key1_words", 128'(KEY), 128'h1918_1110_0908_0100);

    // Wrong-type acknowledge is ignored.
    @(negedge clk); loadDATA = 1'b1;
    @(negedge clk); loadDATA = 1'b0;
    @(posedge clk); #1;
    chk("wrong_ack_newKEY", {127'd0, newKEY}, 128'd1);
    chk("wrong_ack_newDATA", {127'd0, newDATA}, 128'd0);

    // Held-high loadKEY clears once; next key packet stays presented.
    @(negedge clk); loadKEY = 1'b1;
    @(posedge clk); #1;
    chk("held_ack_newKEY", {127'd0, newKEY}, 128'd0);
    p = {8'h20, 8'h2A, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_pkt(p);
    idle();
    wait_new();
    check_pkt("key2");
    repeat (3) @(posedge clk);
    #1 chk("held_ack_no_reclear", {127'd0, newKEY}, 128'd1);
    @(negedge clk); loadKEY = 1'b0;
    @(negedge clk); loadKEY = 1'b1;
    @(negedge clk); loadKEY = 1'b0;
    @(posedge clk); #1;
    chk("key2_ack", {127'd0, newKEY}, 128'd0);

    // Back-to-back data packets while the slot is full.
    p = {8'h00, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(p);
    idle();
    wait_new();
    check_pkt("b2b_a");
    p = {8'h40, 8'h22, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_pkt(p);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_ready_commit", {127'd0, rxREADY}, 128'd0);
    chk("b2b_slot_hold", 128'(inDATA), 128'h0403_0201);
    @(negedge clk); loadDATA = 1'b1;
    @(posedge clk); #1;
    chk("b2b_low_after_A", {127'd0, newDATA}, 128'd0);
    @(negedge clk); loadDATA = 1'b0;
    @(posedge clk); #1;
    chk("b2b_high_after_A1", {127'd0, newDATA}, 128'd1);
    check_pkt("b2b_b");
    @(negedge clk); loadDATA = 1'b1;
    @(negedge clk); loadDATA = 1'b0;

    // Stray non-SOF byte in HEAD.
    send_byte(8'hAA, 1'b0);
    chk("stray_err_pulse", {127'd0, rxERR}, 128'd1);
    idle();
    @(posedge clk); #1;
    chk("stray_err_clear", {127'd0, rxERR}, 128'd0);
    chk("stray_no_packet", {127'd0, newDATA | newKEY}, 128'd0);

    // Mid-packet SOF abandons the data packet; key packet follows.
    send_byte(8'h40, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'h65, 1'b0);
    chk("midsof_no_err_yet", {127'd0, rxERR}, 128'd0);
    p = {8'h60, 8'h05, 8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11, 8'h18, 8'h19};
    sb.push_back(model(p));
    send_byte(p[0], 1'b1);
    chk("midsof_err_pulse", {127'd0, rxERR}, 128'd1);
    send_byte(p[1], 1'b0);
    chk("midsof_err_single", {127'd0, rxERR}, 128'd0);
    for (int i = 2; i < p.size(); i++) send_byte(p[i], 1'b0);
    idle();
    wait_new();
    check_pkt("midsof_key");

    // Reset during PAY with the slot still full.
    send_byte(8'h40, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'h65, 1'b0);
    @(negedge clk);
    nR = 1'b0; rxVALID = 1'b0; rxSOF = 1'b0;
    #1;
    check_cleared("midreset");
    last_data = '0;
    last_key  = '0;
    @(negedge clk); nR = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready", {127'd0, rxREADY}, 128'd1);
    p = {8'h40, 8'h33, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(p);
    idle();
    wait_new();
    check_pkt("post_reset");
    chk("post_reset_sb_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
